// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH+1-bit adder among NREQ requesters.
// Each served request takes three cycles: grant/latch, add, done pulse.
module adder_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      sum,
  output logic                  carry,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] last, win, pick, idx;
  logic            pick_vld;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
    assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
  end

  // First pending requester after the last winner, wrapping modulo NREQ
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDXW'((32'(last) + k) % NREQ);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = CALC;
      CALC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IDXW'(NREQ - 1);
      win      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      gnt      <= '0;
      done     <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            op_a <= a_arr[pick];
            op_b <= b_arr[pick];
            win  <= pick;
            gnt  <= NREQ'(1'b1) << pick;
          end
        end
        CALC: begin
          {carry, sum} <= {1'b0, op_a} + {1'b0, op_b};
          done         <= NREQ'(1'b1) << win;
        end
        DONE: begin
          last     <= win;
          gnt      <= '0;
          op_count <= op_count + CNTW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: expected results queued at stimulus, popped on done.
module tb_adder_share_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNTW  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_in = '0;
  logic [NREQ*WIDTH-1:0] b_in = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      sum;
  logic                  carry;
  logic                  busy;
  logic [CNTW-1:0]       op_count;

  typedef struct {
    logic [NREQ-1:0]  id;
    logic [WIDTH-1:0] sum;
    logic             carry;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_cnt  = 0;
  bit   cnt_pend = 1'b0;
  int   c0;

  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .sum(sum), .carry(carry), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  // Queue the result requester i should receive from its current operands
  task automatic expect_op(input int i);
    exp_t e;
    logic [WIDTH:0] r;
    r       = {1'b0, a_in[i*WIDTH +: WIDTH]} + {1'b0, b_in[i*WIDTH +: WIDTH]};
    e.id    = NREQ'(1) << i;
    e.sum   = r[WIDTH-1:0];
    e.carry = r[WIDTH];
    sb.push_back(e);
  endtask

  task automatic hold_req(input logic [NREQ-1:0] r, input int n);
    req = r;
    repeat (n) @(negedge clk);
    req = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_sum"}, 64'(sum), 0);
    check({tag, "_carry"}, 64'(carry), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_op_count"}, 64'(op_count), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    exp_cnt  = 0;
    cnt_pend = 1'b0;
  endtask

  // Output monitor: invariants, scoreboard pop on done, op_count one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("invariant", 64'($onehot0(gnt) && $onehot0(done) && ((done & ~gnt) == '0)), 1);
      if (cnt_pend) begin
        check("op_count", 64'(op_count), 64'(exp_cnt % (1 << CNTW)));
        cnt_pend = 1'b0;
      end
      if (done != '0) begin
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 0);
        end else begin
          e = sb.pop_front();
          check("done", 64'(done), 64'(e.id));
          check("sum", 64'(sum), 64'(e.sum));
          check("carry", 64'(carry), 64'(e.carry));
        end
        exp_cnt++;
        cnt_pend = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request and grant-to-done latency
    set_op(0, 32'd5, 32'd7);
    expect_op(0);
    done_cyc.delete();
    c0  = cyc;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    check("t1_gnt", 64'(gnt), 64'(4'b0001));
    check("t1_busy", 64'(busy), 1);
    wait_drain();
    check("t1_ndone", 64'(done_cyc.size()), 1);
    check("t1_latency", 64'(done_cyc.size() == 1 ? done_cyc[0] - c0 : -1), 2);
    check("t1_sum_held", 64'(sum), 64'h0C);
    check("t1_count", 64'(op_count), 1);
    check("t1_idle", 64'(busy), 0);

    // Overflow cases
    set_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_op(1);
    hold_req(4'b0010, 1);
    wait_drain();
    set_op(1, 32'h8000_0000, 32'h8000_0000);
    expect_op(1);
    hold_req(4'b0010, 1);
    wait_drain();

    // Round-robin fairness from requester 0
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_op(i, $urandom, $urandom);
      expect_op(i);
    end
    done_cyc.delete();
    hold_req(4'b1111, 12);
    wait_drain();
    check("rr_ndone", 64'(done_cyc.size()), 4);
    for (int k = 1; k < 4; k++) begin
      if (k < done_cyc.size()) check("rr_gap", 64'(done_cyc[k] - done_cyc[k-1]), 3);
    end
    expect_op(1);
    expect_op(3);
    expect_op(1);
    done_cyc.delete();
    hold_req(4'b1010, 9);
    wait_drain();
    check("rr2_ndone", 64'(done_cyc.size()), 3);

    // Operand change and req drop after grant
    set_op(2, 32'd10, 32'd20);
    expect_op(2);
    req = 4'b0100;
    @(negedge clk);
    check("t4_gnt", 64'(gnt), 64'(4'b0100));
    a_in[2*WIDTH +: WIDTH] = 32'd99;
    req = '0;
    wait_drain();

    // Reset during CALC discards the add
    set_op(0, 32'd1, 32'd1);
    req = 4'b0001;
    @(negedge clk);
    check("t5_busy_pre", 64'(busy), 1);
    rst = 1'b1;
    req = '0;
    #1;
    check_zero("midrst");
    exp_cnt  = 0;
    cnt_pend = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_done_cnt", 64'(op_count), 0);
    set_op(0, 32'd1, 32'd2);
    set_op(3, 32'd3, 32'd4);
    expect_op(0);
    expect_op(3);
    hold_req(4'b1001, 6);
    wait_drain();

    // Counter wrap with CNTW=4
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_op(0, $urandom, $urandom);
      expect_op(0);
      hold_req(4'b0001, 1);
      wait_drain();
      if (i == 14) check("wrap_15", 64'(op_count), 15);
      if (i == 15) check("wrap_16", 64'(op_count), 0);
      if (i == 16) check("wrap_17", 64'(op_count), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
